kmkz_writeback: RTL and testbench
=================================

Name: kmkz_writeback

Overview:
- Writeback (W) stage of the Kamikaze-uRV pipeline, and the write-side producer for the register file.
- Registers the execute-stage result and waits for load data from the data bus.
- Aligns and sign-extends sub-word loads.
- Drives the register-file write port and the W-stage bypass, and stalls the pipeline while a load is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a load may wait for data before being aborted (only with KMKZ_WB_TIMEOUT_EN); legal range 2..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active low
- x_valid_i  in  1  execute stage presents an instruction this cycle
- x_rd_i  in  5  destination register index
- x_rd_value_i  in  32  ALU/CSR result
- x_rd_write_i  in  1  instruction writes rd
- x_load_i  in  1  instruction is a load
- x_fun_i  in  3  load funct3
- x_dm_addr_i  in  2  load byte offset (address[1:0])
- dm_data_l_i  in  32  load data; valid only when dm_load_done_i=1
- dm_load_done_i  in  1  load data return strobe
- w_stall_o  out  1  W stage cannot accept; upstream holds
- w_rd_o  out  5  regfile write index
- w_rd_value_o  out  32  regfile write data
- w_rd_store_o  out  1  regfile write enable
- w_bypass_rd_write_o  out  1  bypass valid (equals w_rd_store_o)
- w_bypass_rd_value_o  out  32  bypass data (equals w_rd_value_o)
- w_bus_err_o  out  1  one-cycle load-timeout pulse; tied 0 without the macro

Behaviour:
- Reset: the single clock is clk_i; the asynchronous active-low reset rst_i clears everything.
  - All registers go to 0 and the state to W_IDLE.
  - All outputs are 0 during and immediately after reset.
- Capture: on each rising edge with w_stall_o=0, the W registers latch valid=x_valid_i, plus rd, value, write, load, fun and offset.
  - x_valid_i=0 inserts a bubble.
  - With w_stall_o=1 the registers hold and x_* inputs are ignored.
- States:
  - W_IDLE: no load outstanding.
  - W_LOAD: a valid load has been captured.
  - Capture enters W_LOAD iff x_valid_i & x_load_i, otherwise W_IDLE.
  - W_LOAD exits on dm_load_done_i=1: the write happens that cycle and a new capture may occur on the same edge (back-to-back loads are allowed).
- Stall: w_stall_o = (state==W_LOAD) & ~dm_load_done_i. This is combinational, so there is zero-cycle release on data return.
- Write enable:
  - w_rd_store_o = valid & write & (rd!=0) & (~load | dm_load_done_i).
  - Writes to x0 are never issued.
  - Non-load results write in the cycle after capture (latency 1).
- Load alignment (fun):
  - 000 LB: byte at offset, sign-extended.
  - 100 LBU: byte at offset, zero-extended.
  - 001 LH / 101 LHU: halfword selected by offset[1], sign- or zero-extended; offset[0] ignored.
  - 010 LW and reserved codes 011/110/111: full word.
- w_rd_value_o is the aligned load data when load=1, else the registered value.
- dm_load_done_i in W_IDLE is ignored: no write, no state change.
- Reset mid-load: returns to W_IDLE immediately; a late dm_load_done_i is then ignored.

Optional Feature:
- Macro: KMKZ_WB_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter clears on entry to W_LOAD and increments each W_LOAD cycle without data.
  - When it reaches TIMEOUT_CYCLES-1 and dm_load_done_i=0, the load is aborted: no regfile write, w_bus_err_o pulses for 1 cycle, state returns to W_IDLE, and w_stall_o deasserts that same cycle.
  - Data arriving in the abort cycle takes priority: normal write, no error.
- Without the macro: no counter, W_LOAD waits indefinitely, w_bus_err_o is constant 0.

Decomposition:
- kmkz_defs package/include holds:
  - load funct3 constants (LB/LH/LW/LBU/LHU);
  - state encodings W_IDLE/W_LOAD;
  - default TIMEOUT_CYCLES.
- Sub-module kmkz_load_align: combinational aligner (dm_data, fun, offset -> 32-bit result), unit-testable on its own.

Test Plan:
- Non-load: x_valid=1, rd=5, value=0x12345678, write=1 -> next cycle w_rd_store=1, w_rd=5, w_rd_value=0x12345678, bypass identical, w_stall=0.
- rd=0 write: x_rd=0, write=1 -> w_rd_store stays 0 for all cycles.
- Load with 3-cycle wait: LB, offset=2, data=0x0080FF00 at done -> w_stall=1 for 3 cycles, then w_rd_value=0xFFFFFF80 with store=1 in the done cycle; LBU with the same inputs gives 0x00000080.
- Back-to-back: LHU offset=2, data 0xBEEF1234 (write 0x0000BEEF), then ALU rd=7 value=1 captured on the done edge -> next cycle writes rd7=1, no bubble.
- Reset during W_LOAD, then dm_load_done_i=1 after reset release -> no write, w_stall=0, state W_IDLE.
- With KMKZ_WB_TIMEOUT_EN and TIMEOUT_CYCLES=4: load, no done -> w_stall=1 for 3 cycles, then w_bus_err pulses 1 cycle, no write, w_stall=0; a done arriving in the abort cycle writes normally with w_bus_err=0.

Source files
------------

// File: rtl/kmkz_defs.sv
// Shared definitions for the Kamikaze-uRV writeback stage: load funct3
// encodings, W-stage state encoding and the default load timeout.
package kmkz_defs;

  // Load funct3 encodings; 011/110/111 are reserved and treated as full word.
  localparam logic [2:0] FUN_LB  = 3'b000;
  localparam logic [2:0] FUN_LH  = 3'b001;
  localparam logic [2:0] FUN_LW  = 3'b010;
  localparam logic [2:0] FUN_LBU = 3'b100;
  localparam logic [2:0] FUN_LHU = 3'b101;

  // W-stage occupancy: idle, or holding a load that still waits for data.
  typedef enum logic {
    W_IDLE = 1'b0,
    W_LOAD = 1'b1
  } w_state_e;

  // Cycles a load may wait for data before it is abandoned.
  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/kmkz_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of the
// returned bus word and sign- or zero-extends it according to funct3.
module kmkz_load_align
  import kmkz_defs::*;
(
  input  logic [31:0] dm_data_i,
  input  logic [2:0]  fun_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword lanes (halfword ignores offset[0]).
  always_comb begin
    byte_s = dm_data_i[7:0];
    case (offset_i)
      2'd0:    byte_s = dm_data_i[7:0];
      2'd1:    byte_s = dm_data_i[15:8];
      2'd2:    byte_s = dm_data_i[23:16];
      2'd3:    byte_s = dm_data_i[31:24];
      default: byte_s = dm_data_i[7:0];
    endcase
    if (offset_i[1]) begin
      half_s = dm_data_i[31:16];
    end else begin
      half_s = dm_data_i[15:0];
    end
  end

  // Extend the selected lane to 32 bits; anything not a sub-word load is a word.
  always_comb begin
    result_o = dm_data_i;
    case (fun_i)
      FUN_LB:  result_o = {{24{byte_s[7]}}, byte_s};
      FUN_LBU: result_o = {24'h000000, byte_s};
      FUN_LH:  result_o = {{16{half_s[15]}}, half_s};
      FUN_LHU: result_o = {16'h0000, half_s};
      FUN_LW:  result_o = dm_data_i;
      default: result_o = dm_data_i;
    endcase
  end

endmodule

// File: rtl/kmkz_writeback.sv
// Writeback stage of the Kamikaze-uRV pipeline. Registers the execute result,
// waits for load data, aligns it and drives the register-file write port and
// the W-stage bypass. Stall and write enable are combinational so returning
// load data releases the pipeline in the same cycle.
// Optional build macro KMKZ_WB_TIMEOUT_EN: abort loads that wait
// TIMEOUT_CYCLES cycles without data and pulse w_bus_err_o.
module kmkz_writeback
  import kmkz_defs::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic        x_load_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_o,
  output logic [4:0]  w_rd_o,
  output logic [31:0] w_rd_value_o,
  output logic        w_rd_store_o,
  output logic        w_bypass_rd_write_o,
  output logic [31:0] w_bypass_rd_value_o,
  output logic        w_bus_err_o
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("kmkz_writeback: TIMEOUT_CYCLES must be within 2..255");
  end

  w_state_e    state_q, state_d;
  logic        valid_q, valid_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] value_q, value_d;
  logic        write_q, write_d;
  logic        load_q, load_d;
  logic [2:0]  fun_q, fun_d;
  logic [1:0]  off_q, off_d;

  logic        load_wait_s;
  logic        done_s;
  logic        abort_s;
  logic        stall_s;
  logic        store_s;
  logic [31:0] aligned_s;
  logic [31:0] wdata_s;

  assign load_wait_s = (state_q == W_LOAD);
  assign done_s      = load_wait_s & dm_load_done_i;

`ifdef KMKZ_WB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  assign abort_s = load_wait_s & ~dm_load_done_i & (cnt_q == TIMEOUT_LAST);

  // Wait counter: restarts on every capture, counts data-less W_LOAD cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (~stall_s) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign abort_s = 1'b0;
`endif

  assign stall_s = load_wait_s & ~dm_load_done_i & ~abort_s;

  // Next W contents: capture the execute stage whenever not stalled, else hold.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    value_d = value_q;
    write_d = write_q;
    load_d  = load_q;
    fun_d   = fun_q;
    off_d   = off_q;
    if (~stall_s) begin
      valid_d = x_valid_i;
      rd_d    = x_rd_i;
      value_d = x_rd_value_i;
      write_d = x_rd_write_i;
      load_d  = x_load_i;
      fun_d   = x_fun_i;
      off_d   = x_dm_addr_i;
      if (x_valid_i & x_load_i) begin
        state_d = W_LOAD;
      end else begin
        state_d = W_IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // W-stage pipeline registers and load-wait state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= W_IDLE;
      valid_q <= 1'b0;
      rd_q    <= 5'd0;
      value_q <= 32'h0000_0000;
      write_q <= 1'b0;
      load_q  <= 1'b0;
      fun_q   <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      value_q <= value_d;
      write_q <= write_d;
      load_q  <= load_d;
      fun_q   <= fun_d;
      off_q   <= off_d;
    end
  end

  kmkz_load_align u_align (
    .dm_data_i (dm_data_l_i),
    .fun_i     (fun_q),
    .offset_i  (off_q),
    .result_o  (aligned_s)
  );

  // A valid load only writes in its data-return cycle; x0 is never written.
  assign store_s = valid_q & write_q & (rd_q != 5'd0) & (~load_q | done_s);
  assign wdata_s = load_q ? aligned_s : value_q;

  assign w_stall_o           = stall_s;
  assign w_rd_o              = rd_q;
  assign w_rd_value_o        = wdata_s;
  assign w_rd_store_o        = store_s;
  assign w_bypass_rd_write_o = store_s;
  assign w_bypass_rd_value_o = wdata_s;
  assign w_bus_err_o         = abort_s;

endmodule

// File: tb/tb_kmkz_writeback.sv
// Self-checking bench for kmkz_writeback: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model of
// the W stage (one pending instruction plus a count of cycles waited).
module tb_kmkz_writeback;

`ifdef KMKZ_WB_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        x_valid_i = 1'b0;
  logic [4:0]  x_rd_i = 5'd0;
  logic [31:0] x_rd_value_i = 32'h0;
  logic        x_rd_write_i = 1'b0;
  logic        x_load_i = 1'b0;
  logic [2:0]  x_fun_i = 3'd0;
  logic [1:0]  x_dm_addr_i = 2'd0;
  logic [31:0] dm_data_l_i = 32'h0;
  logic        dm_load_done_i = 1'b0;
  logic        w_stall_o;
  logic [4:0]  w_rd_o;
  logic [31:0] w_rd_value_o;
  logic        w_rd_store_o;
  logic        w_bypass_rd_write_o;
  logic [31:0] w_bypass_rd_value_o;
  logic        w_bus_err_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the W stage contents.
  bit          m_v, m_wr, m_ld;
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  logic [2:0]  m_fun;
  logic [1:0]  m_off;
  int          m_wait;

  kmkz_writeback #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .x_valid_i           (x_valid_i),
    .x_rd_i              (x_rd_i),
    .x_rd_value_i        (x_rd_value_i),
    .x_rd_write_i        (x_rd_write_i),
    .x_load_i            (x_load_i),
    .x_fun_i             (x_fun_i),
    .x_dm_addr_i         (x_dm_addr_i),
    .dm_data_l_i         (dm_data_l_i),
    .dm_load_done_i      (dm_load_done_i),
    .w_stall_o           (w_stall_o),
    .w_rd_o              (w_rd_o),
    .w_rd_value_o        (w_rd_value_o),
    .w_rd_store_o        (w_rd_store_o),
    .w_bypass_rd_write_o (w_bypass_rd_write_o),
    .w_bypass_rd_value_o (w_bypass_rd_value_o),
    .w_bus_err_o         (w_bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference alignment from the load rules, using shifts and masks.
  function automatic logic [31:0] ref_align(logic [31:0] d, logic [2:0] f, logic [1:0] o);
    longint x;
    int     sh;
    int     bits;
    bit     sgn;
    if (f == 3'd0 || f == 3'd4) begin
      sh = int'(o) * 8;  bits = 8;
    end else if (f == 3'd1 || f == 3'd5) begin
      sh = (int'(o) / 2) * 16; bits = 16;
    end else begin
      return d;
    end
    sgn = (f < 3'd4);
    x = (longint'(d) >> sh) & ((longint'(1) << bits) - 1);
    if (sgn && ((x >> (bits - 1)) & 1) == 1) x = x - (longint'(1) << bits);
    return x[31:0];
  endfunction

  task automatic model_clear();
    m_v = 0; m_wr = 0; m_ld = 0; m_rd = 5'd0; m_val = 32'h0;
    m_fun = 3'd0; m_off = 2'd0; m_wait = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance it.
  task automatic step(input bit v, input logic [4:0] rd, input logic [31:0] val,
                      input bit wr, input bit ld, input logic [2:0] fun,
                      input logic [1:0] off, input logic [31:0] data, input bit done);
    bit          pend, abort, e_stall, e_store;
    logic [31:0] e_val;
    @(negedge clk_i);
    rst_i = 1'b1;
    x_valid_i = v; x_rd_i = rd; x_rd_value_i = val; x_rd_write_i = wr;
    x_load_i = ld; x_fun_i = fun; x_dm_addr_i = off;
    dm_data_l_i = data; dm_load_done_i = done;
    #1;
    pend    = m_v && m_ld;
    abort   = TO_EN && pend && !done && (m_wait == TO - 1);
    e_stall = pend && !done && !abort;
    e_store = m_v && m_wr && (m_rd != 5'd0) && (!m_ld || done);
    e_val   = m_ld ? ref_align(data, m_fun, m_off) : m_val;
    chk_eq("stall", 32'(w_stall_o), 32'(e_stall));
    chk_eq("store", 32'(w_rd_store_o), 32'(e_store));
    chk_eq("byp_wr", 32'(w_bypass_rd_write_o), 32'(e_store));
    chk_eq("bus_err", 32'(w_bus_err_o), 32'(abort));
    chk_eq("rd", 32'(w_rd_o), 32'(m_rd));
    chk_eq("value", w_rd_value_o, e_val);
    chk_eq("byp_val", w_bypass_rd_value_o, e_val);
    if (!e_stall) begin
      m_v = v; m_rd = rd; m_val = val; m_wr = wr; m_ld = ld;
      m_fun = fun; m_off = off; m_wait = 0;
    end else begin
      m_wait++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    x_valid_i = 1'b0; x_load_i = 1'b0; x_rd_write_i = 1'b0; dm_load_done_i = 1'b0;
    #1;
    chk_eq("rst_stall", 32'(w_stall_o), 32'h0);
    chk_eq("rst_store", 32'(w_rd_store_o), 32'h0);
    chk_eq("rst_value", w_rd_value_o, 32'h0);
    chk_eq("rst_rd", 32'(w_rd_o), 32'h0);
    chk_eq("rst_err", 32'(w_bus_err_o), 32'h0);
    model_clear();
  endtask

  task automatic idle(input logic [31:0] data, input bit done);
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0, data, done);
  endtask

  initial begin
    model_clear();
    do_reset();

    // ALU result written one cycle after capture.
    step(1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b0);
    idle(32'h0, 1'b0);
    chk_eq("nl_store", 32'(w_rd_store_o), 32'h1);
    chk_eq("nl_value", w_rd_value_o, 32'h1234_5678);
    chk_eq("nl_rd", 32'(w_rd_o), 32'd5);

    // x0 never written.
    step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 1'b0);
    idle(32'h0, 1'b0);
    chk_eq("x0_store", 32'(w_rd_store_o), 32'h0);

    // LB and LBU at offset 2 with a 3-cycle wait; x inputs ignored while stalled.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 5'd3, 32'h0, 1'b1, 1'b1, (k == 0) ? 3'b000 : 3'b100, 2'd2, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 5'd9, 32'h5555_0000, 1'b1, 1'b0, 3'd0, 2'd0, 32'hFFFF_FFFF, 1'b0);
        chk_eq("lb_stall", 32'(w_stall_o), 32'h1);
      end
      idle(32'h0080_FF00, 1'b1);
      chk_eq("lb_store", 32'(w_rd_store_o), 32'h1);
      chk_eq("lb_value", w_rd_value_o, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      chk_eq("lb_stall_rel", 32'(w_stall_o), 32'h0);
    end

    // Back-to-back: LHU then an ALU op captured on the data-return edge.
    step(1'b1, 5'd4, 32'h0, 1'b1, 1'b1, 3'b101, 2'd2, 32'h0, 1'b0);
    step(1'b1, 5'd7, 32'h0000_0001, 1'b1, 1'b0, 3'd0, 2'd0, 32'hBEEF_1234, 1'b1);
    chk_eq("b2b_lhu", w_rd_value_o, 32'h0000_BEEF);
    idle(32'h0, 1'b0);
    chk_eq("b2b_rd", 32'(w_rd_o), 32'd7);
    chk_eq("b2b_val", w_rd_value_o, 32'h1);
    chk_eq("b2b_store", 32'(w_rd_store_o), 32'h1);

    // Reset while a load waits; a late data strobe is ignored.
    step(1'b1, 5'd6, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0);
    idle(32'h0, 1'b0);
    do_reset();
    idle(32'hCAFE_F00D, 1'b1);
    chk_eq("rml_store", 32'(w_rd_store_o), 32'h0);
    chk_eq("rml_stall", 32'(w_stall_o), 32'h0);
    idle(32'h0, 1'b0);
    chk_eq("rml_idle", 32'(w_stall_o), 32'h0);

`ifdef KMKZ_WB_TIMEOUT_EN
    // Timeout abort, then data arriving in the abort cycle.
    step(1'b1, 5'd8, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(32'h0, 1'b0);
      chk_eq("to_stall", 32'(w_stall_o), 32'h1);
    end
    idle(32'h0, 1'b0);
    chk_eq("to_err", 32'(w_bus_err_o), 32'h1);
    chk_eq("to_store", 32'(w_rd_store_o), 32'h0);
    chk_eq("to_stall_rel", 32'(w_stall_o), 32'h0);
    idle(32'h0, 1'b0);
    chk_eq("to_err_pulse", 32'(w_bus_err_o), 32'h0);
    step(1'b1, 5'd8, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) idle(32'h0, 1'b0);
    idle(32'h1357_9BDF, 1'b1);
    chk_eq("to_late_err", 32'(w_bus_err_o), 32'h0);
    chk_eq("to_late_store", 32'(w_rd_store_o), 32'h1);
    chk_eq("to_late_val", w_rd_value_o, 32'h1357_9BDF);
`else
    // Without a timeout a load waits indefinitely and never flags an error.
    step(1'b1, 5'd8, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(32'h0, 1'b0);
      chk_eq("wait_stall", 32'(w_stall_o), 32'h1);
      chk_eq("wait_err", 32'(w_bus_err_o), 32'h0);
    end
    idle(32'h2468_ACE0, 1'b1);
    chk_eq("wait_store", 32'(w_rd_store_o), 32'h1);
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 4) < 2,
             3'($urandom),
             2'($urandom),
             $urandom,
             $urandom_range(0, 9) < 3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
